// File: rtl/uart_rx_decoder.sv
// rtl/uart_rx_decoder.sv - UART receive decoder, 8N1 (or 8E1 with UART_RX_PARITY_EN)
//
// Purpose:
//   Recovers bytes from the asynchronous rxd pin (LSB first, idle high) and
//   hands them to the downstream command/packet parser. Each good byte is
//   announced with a one-cycle rxValid strobe. A low stop bit raises a
//   one-cycle frameErr, and the decoder then waits for the line to go idle.
//
// Parameters:
//   BAUD_DIV  sysClk cycles per bit (>= 4)
//   CNT_W     baud counter width (2**CNT_W > BAUD_DIV)
//
// Ports:
//   sysClk     in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   rxEnable   in   1  receive enable; low aborts any frame and holds IDLE
//   uartRxd    in   1  serial input, asynchronous to sysClk
//   rxData     out  8  last good byte, held until the next good frame
//   rxValid    out  1  one-cycle strobe: rxData was just updated
//   frameErr   out  1  one-cycle strobe: stop bit sampled low
//   parityErr  out  1  one-cycle strobe: even-parity mismatch
//   rxBusy     out  1  decoder is not in IDLE
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8E1 frames with a PARITY state
//                      undefined -> 8N1 frames, parityErr tied to 0

module uart_rx_decoder #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 9
) (
  input  logic       sysClk,
  input  logic       rst,
  input  logic       rxEnable,
  input  logic       uartRxd,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameErr,
  output logic       parityErr,
  output logic       rxBusy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  // Counter value at the middle of the start bit, and at the end of a
  // bit period. Because the counter restarts from 0 at mid-start, each
  // later wrap lands in the middle of the following bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] baud_cnt_q,  baud_cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       sh_q,        sh_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rxd_meta_q,  rxd_meta_d;
  logic             rxd_s_q,     rxd_s_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
  logic             par_bad_q,    par_bad_d;
`endif

  logic baud_tick;

  assign baud_tick = (baud_cnt_q == CNT_LAST);

  // Two-flop synchroniser; only rxd_s_q is seen by the FSM.
  always_comb begin
    rxd_meta_d = uartRxd;
    rxd_s_d    = rxd_meta_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif

    if (!rxEnable) begin
      // Disable aborts silently: no strobe, rxData keeps its value.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s_q) begin
            state_d = ST_START;
          end
        end

        ST_START: begin
          if (baud_cnt_q == CNT_HALF) begin
            if (rxd_s_q) begin
              // Line already back high at mid-start: treat as a glitch.
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
              bit_idx_d = 3'd0;
            end
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            sh_d      = {rxd_s_q, sh_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            // Even parity: data plus parity bit must hold an even number of ones.
            par_bad_d = ^{sh_q, rxd_s_q};
            state_d   = ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (baud_tick) begin
            if (rxd_s_q) begin
              // Returning to IDLE at mid-stop lets a back-to-back start
              // edge at the end of the stop bit be caught.
              state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                parity_err_d = 1'b1;
              end else begin
                rx_data_d  = sh_q;
                rx_valid_d = 1'b1;
              end
`else
              rx_data_d  = sh_q;
              rx_valid_d = 1'b1;
`endif
            end else begin
              // A bad stop bit takes precedence over any parity error.
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          // Hold here until the line idles so a long break gives one frameErr.
          if (rxd_s_q) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Counter restarts on every state change, otherwise free-runs modulo BAUD_DIV.
    if ((state_d != state_q) || baud_tick) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      sh_q        <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign rxData   = rx_data_q;
  assign rxValid  = rx_valid_q;
  assign frameErr = frame_err_q;
  assign rxBusy   = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parityErr = parity_err_q;
`else
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb/tb_uart_rx_decoder.sv - scoreboard testbench for uart_rx_decoder

module tb_uart_rx_decoder;

  localparam int BAUD_DIV = 8;
  localparam int CNT_W    = 4;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic       sysClk;
  logic       rst;
  logic       rxEnable;
  logic       uartRxd;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;
  logic       parityErr;
  logic       rxBusy;

  typedef struct {
    int         kind;
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_rx_decoder #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .sysClk    (sysClk),
    .rst       (rst),
    .rxEnable  (rxEnable),
    .uartRxd   (uartRxd),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .frameErr  (frameErr),
    .parityErr (parityErr),
    .rxBusy    (rxBusy)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] data, input string name);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    uartRxd = b;
    tick(BAUD_DIV);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_bit);
    send_bit(stop_bit);
  endtask
`endif

  // Frames carry correct even parity when the parity build is selected.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge sysClk) begin
    if (!rst && (rxValid || frameErr || parityErr)) begin
      int   act_kind;
      exp_t e;
      act_kind = rxValid ? K_VALID : (frameErr ? K_FERR : K_PERR);
      checks++;
      if ((rxValid && frameErr) || (rxValid && parityErr) || (frameErr && parityErr)) begin
        errors++;
        $display("FAIL strobe_overlap: got valid=%0b ferr=%0b perr=%0b expected one strobe",
                 rxValid, frameErr, parityErr);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got kind=%0d data=%0h expected no strobe", act_kind, rxData);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_kind"}, act_kind, e.kind);
        if (e.kind == K_VALID) check({e.name, "_data"}, rxData, e.data);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    rxEnable = 1'b0;
    uartRxd  = 1'b1;
    tick(3);
    check("reset_rxData", rxData, 8'h00);
    check("reset_rxValid", rxValid, 0);
    check("reset_frameErr", frameErr, 0);
    check("reset_parityErr", parityErr, 0);
    check("reset_rxBusy", rxBusy, 0);
    rst      = 1'b0;
    rxEnable = 1'b1;
    tick(5);

    // 1: single good frame, with rxBusy timing around the start edge
    push(K_VALID, 8'hA5, "t1_a5");
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge sysClk);
        @(posedge sysClk);
        @(negedge sysClk);
        check("t1_busy_before", rxBusy, 0);
        @(posedge sysClk);
        @(negedge sysClk);
        check("t1_busy_start", rxBusy, 1);
      end
    join
    @(negedge sysClk);
    check("t1_busy_after", rxBusy, 0);
    check("t1_rxData", rxData, 8'hA5);
    tick(4);

    // 2: short glitch is rejected
    uartRxd = 1'b0;
    tick(3);
    check("t2_busy_glitch", rxBusy, 1);
    uartRxd = 1'b1;
    tick(20);
    check("t2_busy_idle", rxBusy, 0);
    check("t2_rxData", rxData, 8'hA5);

    // 3: bad stop bit then long break, then recovery
    push(K_FERR, 8'h00, "t3_ferr");
    send_frame(8'h3C, 1'b0);
    uartRxd = 1'b0;
    tick(40);
    check("t3_busy_break", rxBusy, 1);
    uartRxd = 1'b1;
    tick(16);
    check("t3_rxData_held", rxData, 8'hA5);
    check("t3_busy_idle", rxBusy, 0);
    push(K_VALID, 8'h81, "t3_81");
    send_frame(8'h81, 1'b1);
    tick(4);
    check("t3_rxData_81", rxData, 8'h81);

    // 4: back-to-back frames with no idle gap
    push(K_VALID, 8'h00, "t4_00");
    push(K_VALID, 8'hFF, "t4_ff");
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(4);
    check("t4_rxData", rxData, 8'hFF);

    // 5a: reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    rst = 1'b1;
    tick(2);
    check("t5_rst_rxData", rxData, 8'h00);
    check("t5_rst_busy", rxBusy, 0);
    check("t5_rst_valid", rxValid, 0);
    check("t5_rst_ferr", frameErr, 0);
    uartRxd = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    push(K_VALID, 8'h12, "t5_12");
    send_frame(8'h12, 1'b1);
    tick(4);
    check("t5_rxData_12", rxData, 8'h12);

    // 5b: rxEnable dropped in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    rxEnable = 1'b0;
    tick(1);
    check("t5_dis_busy", rxBusy, 0);
    uartRxd = 1'b1;
    tick(4);
    rxEnable = 1'b1;
    tick(4);
    check("t5_dis_rxData", rxData, 8'h12);
    push(K_VALID, 8'h34, "t5_34");
    send_frame(8'h34, 1'b1);
    tick(4);
    check("t5_rxData_34", rxData, 8'h34);

`ifdef UART_RX_PARITY_EN
    // 6: parity error then good parity
    push(K_PERR, 8'h00, "t6_perr");
    send_frame_par(8'h07, 1'b0, 1'b1);
    tick(4);
    check("t6_rxData_held", rxData, 8'h34);
    push(K_VALID, 8'h07, "t6_07");
    send_frame_par(8'h07, 1'b1, 1'b1);
    tick(4);
    check("t6_rxData_07", rxData, 8'h07);
`else
    tick(4);
    check("t6_parityErr_tied", parityErr, 0);
`endif

    tick(20);
    check("pending_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
